// File: rtl/step5_led_pio_pkg.sv
// Shared definitions for the LED output PIO: register map of the 4-word slave span.
package step5_led_pio_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA = 2'd0,
      ADDR_MASK = 2'd1,
      ADDR_SET  = 2'd2,
      ADDR_CLR  = 2'd3
   } reg_addr_e;

endpackage

// File: rtl/step5_blink_timer.sv
// Free-running blink timer: toggles phase every BLINK_DIV clocks, restartable to phase 0.
module step5_blink_timer #(
   parameter int BLINK_DIV = 25000000,
   parameter int CNT_W     = 25
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic phase
);

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BLINK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   // restart wins over terminal count so a mask write always begins a clean period
   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == CNT_TC) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/step5_led_pio.sv
// Avalon-MM LED output PIO: data register, blink mask, atomic set/clear, registered readback.
module step5_led_pio
   import step5_led_pio_pkg::*;
#(
   parameter int WIDTH     = 10,
   parameter int BLINK_DIV = 25000000,
   parameter int CNT_W     = 25
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [WIDTH-1:0] wd;
   logic             wr;
   logic             restart;
   logic             phase;

   assign wr = chipselect & ~write_n;
   assign wd = writedata[WIDTH-1:0];

   generate
      if (WIDTH < 32) begin : g_unused_wd
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:WIDTH];
      end
   endgenerate

   step5_blink_timer #(
      .BLINK_DIV (BLINK_DIV),
      .CNT_W     (CNT_W)
   ) u_blink_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .restart (restart),
      .phase   (phase)
   );

   always_comb begin
      data_d  = data_q;
      mask_d  = mask_q;
      restart = 1'b0;
      if (wr) begin
         case (reg_addr_e'(address))
            ADDR_DATA: data_d = wd;
            ADDR_MASK: begin
               mask_d  = wd;
               restart = 1'b1;
            end
            ADDR_SET:  data_d = data_q | wd;
            ADDR_CLR:  data_d = data_q & ~wd;
         endcase
      end
   end

   // reads ignore chipselect; addr2 returns what is actually on the pins
   always_comb begin
      out_d   = data_q ^ (mask_q & {WIDTH{phase}});
      rdata_d = '0;
      case (reg_addr_e'(address))
         ADDR_DATA: rdata_d[WIDTH-1:0] = data_q;
         ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
         ADDR_SET:  rdata_d[WIDTH-1:0] = out_q;
         ADDR_CLR:  rdata_d[0]         = phase;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= '0;
         mask_q  <= '0;
         out_q   <= '0;
         rdata_q <= '0;
      end else begin
         data_q  <= data_d;
         mask_q  <= mask_d;
         out_q   <= out_d;
         rdata_q <= rdata_d;
      end
   end

   assign readdata = rdata_q;
   assign out_port = out_q;

endmodule

// File: doc/step5_led_pio.md
Name: step5_led_pio

Overview:
- Avalon-MM slave output PIO; the write-side counterpart of the switch input PIO. Drives the board LEDs.
- Software writes a data register and a per-bit blink mask. Output bits under the mask toggle at a fixed divided rate, with no CPU involvement.
- Atomic set and clear writes let HPS/Nios code change individual LEDs without a read-modify-write.
- Sits on the lightweight bridge beside the switch PIO, 4-word span.

Parameters:
WIDTH, 10, number of output bits (LEDR[9:0])
BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); must be >= 2
CNT_W, 25, counter width; must satisfy 2**CNT_W >= BLINK_DIV

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  word address within slave span
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data; bits above WIDTH-1 ignored
readdata  out  32  registered read data
out_port  out  WIDTH  LED drive

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: data_reg=0, mask_reg=0, cnt=0, phase=0, readdata=0, out_port=0.
- Register map:
  - addr0 DATA: R/W.
  - addr1 BLINK_MASK: R/W.
  - addr2: write = OUTSET (data_reg |= wd); read = live out_port.
  - addr3: write = OUTCLEAR (data_reg &= ~wd); read = {31'b0, phase}.
- Write strobe: wr = chipselect & ~write_n. Registers update on the rising edge where wr=1. Zero wait states.
- Read path:
  - readdata is updated every cycle from address, independent of chipselect; read latency 1.
  - Upper bits are zero-extended.
  - A read in the cycle after a write returns the new value.
- Output: out_port = data_reg ^ (mask_reg & {WIDTH{phase}}), registered. It changes one cycle after the data_reg/mask_reg/phase update.
- Blink counter:
  - cnt increments every cycle.
  - When cnt==BLINK_DIV-1: cnt wraps to 0 and phase toggles.
  - The counter free-runs regardless of mask value.
- Write to BLINK_MASK: cnt<=0 and phase<=0 in the same edge as the mask update. This takes priority over the terminal-count toggle.
- Simultaneous events:
  - DATA/OUTSET/OUTCLEAR write coinciding with terminal count: both take effect. The next out_port uses the new data and the toggled phase.
  - Only one register is written per cycle, since there is a single address.
- Mask bit cleared while phase=1: that bit immediately shows data_reg, with no stuck inversion. phase also resets, per the mask-write rule.
- Reset asserted mid-blink: everything returns to reset values asynchronously. On release the counter restarts from 0.
- No behaviour is defined for addresses outside 0..3; the 2-bit address makes them unreachable.

Decomposition:
- Shared package: register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_SET=2, ADDR_CLR=3.
- One sub-module: step5_blink_timer (params BLINK_DIV, CNT_W).
  - Inputs: clk, reset_n, restart.
  - Output: phase.
- Register file, write decode and read mux stay in the top module.

Test Plan (BLINK_DIV=4):
- Reset: hold reset_n=0 with writedata=all 1s and wr=1 -> out_port=0 and readdata=0. After release, a read of addr0 returns 0.
- DATA write/read: write addr0=0x2A5 -> out_port=0x2A5 one cycle later. Read addr0 returns 0x000002A5; read addr2 returns 0x2A5.
- OUTSET/OUTCLEAR: from 0x2A5, write addr2=0x00A -> data 0x2AF. Then write addr3=0x201 -> data 0x0AE. Reads of addr0 confirm each value; bits above 9 of writedata (0xFFFFFC00) have no effect.
- Blink: DATA=0x001, write MASK=0x003.
  - out_port alternates 0x001 / 0x002 every 4 cycles.
  - addr3 reads phase 0/1 in step with out_port.
  - Writing MASK again mid-period restarts the 4-cycle count with phase=0.
- Coincidence: OUTSET 0x100 issued exactly at terminal count -> the next out_port equals (0x101)^0x003 or 0x101 according to the new phase. No lost write, no missed toggle.
- Async reset mid-blink at phase=1: out_port goes to 0 without a clk edge. After release, the first toggle occurs 4 cycles later.
